// File: rtl/coef_loader_if.sv
// coef_loader_if -- 4-phase coefficient request/acknowledge channel.
//   cfg_req  : loader asks for the next coefficient (loader is the requester)
//   cfg_ack  : source acknowledge; cfg_data is valid while cfg_ack=1
//   cfg_data : coefficient value, two's complement
// Modports: master = loader side, slave = coefficient source side.
interface coef_loader_if #(
   parameter int DWIDTH = 16
);
   logic              cfg_req;
   logic              cfg_ack;
   logic [0:DWIDTH-1] cfg_data;

   modport master (output cfg_req, input cfg_ack, input cfg_data);
   modport slave  (input cfg_req, output cfg_ack, output cfg_data);
endinterface

// File: rtl/coef_loader.sv
// coef_loader -- configuration sequencer for the 2-parallel FIR filter.
// Collects NR_STAGES coefficients over a 4-phase req/ack channel into a
// shadow bank, then swaps the whole bank onto the filter coefficient bus
// while holding the filter in reset for RST_CYCLES cycles.
// Ports:
//   clk_i        system clock, posedge
//   rst_i        synchronous active-high reset
//   upd_start_i  one-cycle request to load a new coefficient set
//   cfg          coefficient channel (master side: cfg_req out, cfg_ack/cfg_data in)
//   h_out_o      active coefficient bank, tap k at bits [k*DWIDTH +: DWIDTH]
//   filt_rst_o   reset to the filter
//   busy_o       high whenever the sequencer is not idle
//   done_o       one-cycle pulse when a swap completes
module coef_loader #(
   parameter int NR_STAGES  = 32,
   parameter int DWIDTH     = 16,
   parameter int CWIDTH     = NR_STAGES*DWIDTH,
   parameter int RST_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              upd_start_i,
   coef_loader_if.master     cfg,
   output logic [0:CWIDTH-1] h_out_o,
   output logic              filt_rst_o,
   output logic              busy_o,
   output logic              done_o
);
   localparam int IDX_W = (NR_STAGES  > 1) ? $clog2(NR_STAGES)  : 1;
   localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NR_STAGES-1);
   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RST_CYCLES-1);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_LOW, SWAP, HOLD} state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [0:CWIDTH-1] shadow_q, shadow_d;
   logic [0:CWIDTH-1] h_q, h_d;
   logic              req_q, req_d;
   logic              frst_q, frst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      h_d      = h_q;
      req_d    = req_q;
      frst_d   = frst_q;
      done_d   = 1'b0;
      busy_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Also releases the filter on the first cycle after reset.
            frst_d = 1'b0;
            if (upd_start_i) begin
               idx_d   = '0;
               req_d   = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            // An ack already high when req rises is taken in this same cycle.
            if (cfg.cfg_ack) begin
               shadow_d[int'(idx_q)*DWIDTH +: DWIDTH] = cfg.cfg_data;
               req_d   = 1'b0;
               state_d = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            // Complete the 4-phase cycle before asking for the next tap.
            if (!cfg.cfg_ack) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = SWAP;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  req_d   = 1'b1;
                  state_d = LOAD;
               end
            end
         end
         SWAP: begin
            // New bank and filter reset land together, so the filter never
            // runs on a partially updated bank.
            h_d     = shadow_q;
            frst_d  = 1'b1;
            cnt_d   = HOLD_INIT;
            state_d = HOLD;
         end
         HOLD: begin
            if (cnt_q == '0) begin
               frst_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         h_q      <= '0;
         req_q    <= 1'b0;
         frst_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         h_q      <= h_d;
         req_q    <= req_d;
         frst_q   <= frst_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign cfg.cfg_req = req_q;
   assign h_out_o     = h_q;
   assign filt_rst_o  = frst_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
endmodule

// File: tb/tb_coef_loader.sv
// Bench for coef_loader: DUT A (4 taps, RST_CYCLES=2) and DUT B (4 taps,
// RST_CYCLES=1). Expected banks are queued as each set is handed over; a
// negedge monitor pops them when filt_rst rises and checks the bank, the
// filt_rst width, the done pulse and that h_out never moves outside a swap.
module tb_coef_loader;
   localparam int NS = 4;
   localparam int DW = 16;
   localparam int CW = NS*DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          upd_a, upd_b;
   logic [0:CW-1] h_a, h_b;
   logic          frst_a, frst_b, busy_a, busy_b, done_a, done_b;

   coef_loader_if #(.DWIDTH(DW)) ifa();
   coef_loader_if #(.DWIDTH(DW)) ifb();

   coef_loader #(.NR_STAGES(NS), .DWIDTH(DW), .RST_CYCLES(2)) dut_a (
      .clk_i(clk), .rst_i(rst), .upd_start_i(upd_a), .cfg(ifa),
      .h_out_o(h_a), .filt_rst_o(frst_a), .busy_o(busy_a), .done_o(done_a));

   coef_loader #(.NR_STAGES(NS), .DWIDTH(DW), .RST_CYCLES(1)) dut_b (
      .clk_i(clk), .rst_i(rst), .upd_start_i(upd_b), .cfg(ifb),
      .h_out_o(h_b), .filt_rst_o(frst_b), .busy_o(busy_b), .done_o(done_b));

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] exp_a[$];
   logic [63:0] exp_b[$];
   logic [63:0] model_bank_a = '0;

   // monitor state, index 0 = DUT A, 1 = DUT B
   logic [63:0] h_prev[2]    = '{64'd0, 64'd0};
   logic        frst_prev[2] = '{1'b1, 1'b1};
   logic        req_prev[2]  = '{1'b0, 1'b0};
   bit          swap_act[2]  = '{1'b0, 1'b0};
   int          hi_cnt[2]    = '{0, 0};
   int          done_cnt[2]  = '{0, 0};
   int          req_rises[2] = '{0, 0};
   int          rst_len[2]   = '{2, 1};
   logic        rst_prev     = 1'b1;
   bit          mon_en       = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got timeout, expected event", nm);
   endtask

   task automatic mon(input int d, input logic [63:0] h, input logic fr,
                      input logic dn, input logic rq, input logic bz);
      logic [63:0] e;
      bit          rise;
      rise = fr && !frst_prev[d] && !rst;
      if (rst) swap_act[d] = 1'b0;
      if (rise) begin
         if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
            tmo($sformatf("unexpected_swap[%0d]", d));
         end else begin
            if (d == 0) e = exp_a.pop_front();
            else        e = exp_b.pop_front();
            chk($sformatf("h_out_at_swap[%0d]", d), h, e);
         end
         swap_act[d] = 1'b1;
         hi_cnt[d]   = 1;
      end else if (swap_act[d] && fr) begin
         hi_cnt[d]++;
      end else if (swap_act[d] && !fr) begin
         chk($sformatf("filt_rst_width[%0d]", d), 64'(hi_cnt[d]), 64'(rst_len[d]));
         chk($sformatf("done_with_release[%0d]", d), 64'(dn), 64'd1);
         chk($sformatf("busy_falls_with_done[%0d]", d), 64'(bz), 64'd0);
         swap_act[d] = 1'b0;
      end
      if (!rise && !rst && !rst_prev && h !== h_prev[d]) begin
         n_tests++;
         n_fail++;
         $display("FAIL h_out_moved[%0d]: got 0x%0h, expected 0x%0h", d, h, h_prev[d]);
      end
      if (dn) done_cnt[d]++;
      if (rq && !req_prev[d]) req_rises[d]++;
      h_prev[d]    = h;
      frst_prev[d] = fr;
      req_prev[d]  = rq;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, h_a, frst_a, done_a, ifa.cfg_req, busy_a);
         mon(1, h_b, frst_b, done_b, ifb.cfg_req, busy_b);
         rst_prev = rst;
      end
   end

   // DUT B source: answers every request at once with a random word.
   logic [15:0] cur_b[$];
   always @(negedge clk) begin
      if (rst) begin
         ifb.cfg_ack = 1'b0;
         cur_b.delete();
      end else if (ifb.cfg_req && !ifb.cfg_ack) begin
         ifb.cfg_data = 16'($urandom);
         ifb.cfg_ack  = 1'b1;
         cur_b.push_back(ifb.cfg_data);
         if (cur_b.size() == NS) begin
            exp_b.push_back({cur_b[0], cur_b[1], cur_b[2], cur_b[3]});
            cur_b.delete();
         end
      end else if (ifb.cfg_ack && !ifb.cfg_req) begin
         ifb.cfg_ack = 1'b0;
      end
   end

   // DUT A source: one 4-phase word with programmable delay and ack hold.
   task automatic src_word(input logic [15:0] w, input int dly, input int hold, input bit upd_mid);
      int t;
      t = 0;
      while (ifa.cfg_req !== 1'b1) begin
         @(negedge clk);
         t++;
         if (t > 200) begin tmo("cfg_req_rise"); return; end
      end
      if (upd_mid) begin
         upd_a = 1'b1;
         @(negedge clk);
         upd_a = 1'b0;
      end
      repeat (dly) @(negedge clk);
      ifa.cfg_data = w;
      ifa.cfg_ack  = 1'b1;
      repeat (hold) @(negedge clk);
      t = 0;
      while (ifa.cfg_req !== 1'b0) begin
         @(negedge clk);
         t++;
         if (t > 200) begin tmo("cfg_req_fall"); return; end
      end
      chk("h_out_stable_while_loading", h_a, model_bank_a);
      ifa.cfg_ack  = 1'b0;
      ifa.cfg_data = 16'($urandom);
   endtask

   task automatic run_load(input logic [15:0] w[4], input int dly, input int hold,
                           input bit pre, input int upd_at);
      int r0, d0, t;
      r0 = req_rises[0];
      d0 = done_cnt[0];
      if (pre) begin
         ifa.cfg_data = w[0];
         ifa.cfg_ack  = 1'b1;
         repeat (2) @(negedge clk);
         chk("idle_ignores_ack_req", 64'(ifa.cfg_req), 64'd0);
         chk("idle_ignores_ack_busy", 64'(busy_a), 64'd0);
      end
      upd_a = 1'b1;
      @(negedge clk);
      upd_a = 1'b0;
      for (int k = 0; k < NS; k++) begin
         src_word(w[k], dly, hold, k == upd_at);
         if (k == NS-1) exp_a.push_back({w[0], w[1], w[2], w[3]});
      end
      t = 0;
      while (done_cnt[0] == d0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) tmo("done_a");
      repeat (3) @(negedge clk);
      chk("done_pulses", 64'(done_cnt[0] - d0), 64'd1);
      chk("cfg_req_rises", 64'(req_rises[0] - r0), 64'(NS));
      chk("busy_idle_after", 64'(busy_a), 64'd0);
      model_bank_a = {w[0], w[1], w[2], w[3]};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] wv[4];
      int          t, d0;
      rst          = 1'b1;
      upd_a        = 1'b0;
      upd_b        = 1'b0;
      ifa.cfg_ack  = 1'b0;
      ifa.cfg_data = '0;

      // 1. reset release
      @(negedge clk);
      mon_en = 1'b1;
      chk("rst_filt_rst_a", 64'(frst_a), 64'd1);
      chk("rst_h_out_a", h_a, 64'd0);
      chk("rst_busy_a", 64'(busy_a), 64'd0);
      chk("rst_req_a", 64'(ifa.cfg_req), 64'd0);
      chk("rst_done_a", 64'(done_a), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("filt_rst_held_a", 64'(frst_a), 64'd1);
      chk("filt_rst_held_b", 64'(frst_b), 64'd1);
      @(negedge clk);
      chk("filt_rst_released_a", 64'(frst_a), 64'd0);
      chk("filt_rst_released_b", 64'(frst_b), 64'd0);
      chk("idle_h_out_b", h_b, 64'd0);

      // 2. full load, immediate acks
      wv = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
      run_load(wv, 0, 1, 1'b0, -1);
      chk("h_out_full_load", h_a, 64'h0001_FFFF_7FFF_8000);

      // 3. slow source
      for (int k = 0; k < NS; k++) wv[k] = 16'($urandom);
      run_load(wv, 5, 3, 1'b0, -1);

      // 4. ack in IDLE, upd_start during LOAD of word 2, ack high before req
      ifa.cfg_ack = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_ack_no_req", 64'(ifa.cfg_req), 64'd0);
      ifa.cfg_ack = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NS; k++) wv[k] = 16'($urandom);
      run_load(wv, 2, 1, 1'b0, 1);
      for (int k = 0; k < NS; k++) wv[k] = 16'($urandom);
      run_load(wv, 0, 1, 1'b1, -1);

      // randomized handshake timing
      for (int s = 0; s < 6; s++) begin
         for (int k = 0; k < NS; k++) wv[k] = 16'($urandom);
         run_load(wv, int'($urandom_range(0, 4)), int'($urandom_range(1, 3)), 1'b0, -1);
      end

      // 5. reset mid-load
      upd_a = 1'b1;
      @(negedge clk);
      upd_a = 1'b0;
      src_word(16'h1111, 1, 1, 1'b0);
      src_word(16'h2222, 1, 1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("midload_rst_h_out", h_a, 64'd0);
      chk("midload_rst_req", 64'(ifa.cfg_req), 64'd0);
      chk("midload_rst_busy", 64'(busy_a), 64'd0);
      chk("midload_rst_filt_rst", 64'(frst_a), 64'd1);
      rst = 1'b0;
      model_bank_a = '0;
      repeat (2) @(negedge clk);
      chk("midload_idle_busy", 64'(busy_a), 64'd0);
      chk("midload_filt_rst_low", 64'(frst_a), 64'd0);
      wv = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      run_load(wv, 1, 1, 1'b0, -1);
      chk("h_out_after_rst_reload", h_a, 64'h0001_0002_0003_0004);

      // 6. RST_CYCLES=1, back-to-back loads on DUT B
      d0 = done_cnt[1];
      upd_b = 1'b1;
      @(negedge clk);
      upd_b = 1'b0;
      t = 0;
      while (done_b !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) tmo("done_b_first");
      upd_b = 1'b1;
      @(negedge clk);
      upd_b = 1'b0;
      chk("b2b_second_load_req", 64'(ifb.cfg_req), 64'd1);
      t = 0;
      while (done_cnt[1] < d0 + 2 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) tmo("done_b_second");
      repeat (3) @(negedge clk);
      chk("b2b_done_pulses", 64'(done_cnt[1] - d0), 64'd2);
      chk("b2b_busy_idle", 64'(busy_b), 64'd0);

      chk("scoreboard_a_drained", 64'(exp_a.size()), 64'd0);
      chk("scoreboard_b_drained", 64'(exp_b.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
